// File: rtl/t_ctrl_pkg.sv
// Shared types for the T-cell counter controller.
// State encoding and count-direction constants.
package t_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/t_ff_cell.sv
// One-bit T flip-flop with synchronous active-high reset.
// Building block of the counter register.
module t_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // toggle on t, clear on reset
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/t_counter_ctrl.sv
// Programmable modulo up/down counter: FSM drives
// only the toggle enables of a T flip-flop array.
module t_counter_ctrl
  import t_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             reload,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] limit_r;
  logic             dir_r;
  logic             reload_r;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] dec_t;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] run_start;
  logic [WIDTH-1:0] new_start;
  logic             at_term;

  assign term      = (dir_r == DIR_DOWN) ? '0 : limit_r;
  assign run_start = (dir_r == DIR_DOWN) ? limit_r : '0;
  assign new_start = (dir == DIR_DOWN) ? limit : '0;
  assign at_term   = (count == term);

  // ripple toggle chains for increment and decrement
  always_comb begin
    inc_t    = '0;
    dec_t    = '0;
    inc_t[0] = 1'b1;
    dec_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_t[i] = inc_t[i-1] & count[i-1];
      dec_t[i] = dec_t[i-1] & ~count[i-1];
    end
  end

  // toggle vector: hold, load, restart or step
  always_comb begin
    t = '0;
    unique case (1'b1)
      (state == ST_RUN): begin
        if (!stop) begin
          if (at_term) begin
            if (reload_r) t = count ^ run_start;
          end else if (dir_r == DIR_DOWN) begin
            t = dec_t;
          end else begin
            t = inc_t;
          end
        end
      end
      default: begin
        if (stop) t = '0;
        else if (start) t = count ^ new_start;
        else if (load) t = count ^ load_val;
      end
    endcase
  end

  // FSM, config latches and registered flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      limit_r  <= '0;
      dir_r    <= 1'b0;
      reload_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tc       <= 1'b0;
    end else begin
      tc <= 1'b0;
      unique case (1'b1)
        (state == ST_RUN): begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (at_term) begin
            tc <= 1'b1;
            if (!reload_r) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          if (stop) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            limit_r  <= limit;
            dir_r    <= dir;
            reload_r <= reload;
          end else if (load) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t[g]),
      .q     (count[g])
    );
  end

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Random + directed bench for t_counter_ctrl.
// Reference model works on integer counts and modes.
module tb_t_counter_ctrl;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         dir;
  logic         reload;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt  = 0;
  int m_lim  = 0;
  int m_mode = 0;
  bit m_dir  = 0;
  bit m_rel  = 0;
  bit m_tc   = 0;

  always #5 clk = ~clk;

  t_counter_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .reload   (reload),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  task automatic expect_eq(input string tag,
                           input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode: 0 idle, 1 counting, 2 finished
  task automatic model_step();
    int term;
    if (reset) begin
      m_cnt = 0; m_mode = 0; m_tc = 0;
      m_lim = 0; m_dir = 0; m_rel = 0;
      return;
    end
    m_tc = 0;
    if (m_mode == 1) begin
      term = m_dir ? 0 : m_lim;
      if (stop) m_mode = 0;
      else if (m_cnt == term) begin
        m_tc = 1;
        if (m_rel) m_cnt = m_dir ? m_lim : 0;
        else m_mode = 2;
      end else if (m_dir) m_cnt = (m_cnt + M - 1) % M;
      else m_cnt = (m_cnt + 1) % M;
    end else begin
      if (stop) m_mode = 0;
      else if (start) begin
        m_lim = int'(limit);
        m_dir = dir;
        m_rel = reload;
        m_cnt = dir ? m_lim : 0;
        m_mode = 1;
      end else if (load) begin
        m_cnt = int'(load_val);
        m_mode = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    expect_eq("count", 32'(count), 32'(m_cnt));
    expect_eq("busy", 32'(busy), 32'(m_mode == 1));
    expect_eq("done", 32'(done), 32'(m_mode == 2));
    expect_eq("tc", 32'(tc), 32'(m_tc));
  endtask

  task automatic clr();
    reset = 0; start = 0; stop = 0; load = 0;
  endtask

  int tcs;
  int k;

  initial begin
    clr();
    dir = 0; reload = 0; limit = '0; load_val = '0;
    reset = 1; cycle(); clr();

    // reset from a loaded value
    load = 1; load_val = 5; cycle(); clr();
    expect_eq("t1_pre", 32'(count), 32'd5);
    reset = 1; cycle(); clr();
    expect_eq("t1_count", 32'(count), 32'd0);
    expect_eq("t1_busy", 32'(busy), 32'd0);

    // one-shot up to 3
    limit = 3; dir = 0; reload = 0; start = 1; cycle(); clr();
    repeat (5) cycle();
    expect_eq("t2_done", 32'(done), 32'd1);
    expect_eq("t2_count", 32'(count), 32'd3);

    // reload down from 2
    limit = 2; dir = 1; reload = 1; start = 1; cycle(); clr();
    tcs = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      tcs += int'(tc);
    end
    expect_eq("t3_tcs", 32'(tcs), 32'd3);
    expect_eq("t3_busy", 32'(busy), 32'd1);

    // stop mid-run, then load
    stop = 1; cycle(); clr();
    limit = 9; dir = 0; reload = 0; start = 1; cycle(); clr();
    k = 0;
    while (count != 4 && k < 20) begin
      cycle();
      k++;
    end
    expect_eq("t4_reach", 32'(count), 32'd4);
    stop = 1; cycle(); clr();
    expect_eq("t4_hold", 32'(count), 32'd4);
    load = 1; load_val = 11; cycle(); clr();
    expect_eq("t4_load", 32'(count), 32'd11);

    // full-range reload; start beats load
    limit = 15; dir = 0; reload = 1;
    start = 1; load = 1; load_val = 7; cycle(); clr();
    expect_eq("t5_start", 32'(count), 32'd0);
    tcs = 0;
    for (int i = 0; i < 33; i++) begin
      cycle();
      tcs += int'(tc);
    end
    expect_eq("t5_tcs", 32'(tcs), 32'd2);
    stop = 1; cycle(); clr();

    // load ignored in run, reset mid-run
    limit = 10; dir = 0; reload = 0; start = 1; cycle(); clr();
    for (int i = 0; i < 3; i++) begin
      load = 1; load_val = 13; cycle(); clr();
    end
    repeat (3) cycle();
    expect_eq("t6_six", 32'(count), 32'd6);
    reset = 1; cycle(); clr();
    expect_eq("t6_count", 32'(count), 32'd0);
    expect_eq("t6_tc", 32'(tc), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 7) == 0);
      dir      = 1'($urandom_range(0, 1));
      reload   = 1'($urandom_range(0, 1));
      limit    = W'($urandom_range(0, M - 1));
      load_val = W'($urandom_range(0, M - 1));
      cycle();
    end
    clr();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
